// File: rtl/video_timing_detector.sv
// video_timing_detector: rebuilds line/pixel counters from active-low syncs,
// measures line length and frame height, classifies the timing and tracks lock.
module video_timing_detector #(
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic [8:0] line_len,
    output logic [8:0] frame_lines,
    output logic       frame_strobe,
    output logic       locked,
    output logic [1:0] mode,
    output logic       mode_valid
);

    localparam int unsigned CW      = 9;
    localparam int unsigned MCW     = 3;
    localparam logic [CW-1:0]  CNT_MAX = CW'(511);
    localparam logic [MCW-1:0] LOCK_MC = MCW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    logic            hs_q, vs_q;
    logic [CW-1:0]   hcnt_q, vcnt_q, line_len_q, frame_lines_q;
    logic            frame_strobe_q;
    state_e          state_q, state_d;
    logic [MCW-1:0]  mc_q, mc_d;
    logic            locked_q, locked_d;
    logic [1:0]      mode_q, mode_d;
    logic            mode_valid_q, mode_valid_d;
    logic [2*CW-1:0] prev_q, prev_d;
    logic            prev_vld_q, prev_vld_d;

    logic            hedge_c, vedge_c, timeout_c, match_c;
    logic [1:0]      match_mode_c;
    logic [2*CW-1:0] pair_c;

    assign hedge_c   = clken & hs_q & ~hsync_in;
    assign vedge_c   = clken & vs_q & ~vsync_in;
    assign timeout_c = (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX);
    assign pair_c    = {line_len_q, frame_lines_q};

    // Sync sampling, sync-relative counters and per-edge measurements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            hcnt_q         <= '0;
            vcnt_q         <= '0;
            line_len_q     <= '0;
            frame_lines_q  <= '0;
            frame_strobe_q <= 1'b0;
        end else begin
            frame_strobe_q <= vedge_c;
            if (clken) begin
                hs_q <= hsync_in;
                vs_q <= vsync_in;
            end
            if (hedge_c) begin
                hcnt_q     <= '0;
                line_len_q <= hcnt_q;
            end else if (clken && (hcnt_q != CNT_MAX)) begin
                hcnt_q <= hcnt_q + CW'(1);
            end
            if (vedge_c) begin
                vcnt_q        <= '0;
                frame_lines_q <= vcnt_q - CW'(1) + CW'(hedge_c);
            end else if (hedge_c && (vcnt_q != CNT_MAX)) begin
                vcnt_q <= vcnt_q + CW'(1);
            end
        end
    end

    // Known-timing lookup on the measured pair.
    always_comb begin
        match_c      = 1'b1;
        match_mode_c = mode_q;
        case (pair_c)
            {CW'(447), CW'(311)}: match_mode_c = 2'b00;
            {CW'(455), CW'(310)}: match_mode_c = 2'b01;
            {CW'(447), CW'(319)}: match_mode_c = 2'b10;
            {CW'(447), CW'(261)}: match_mode_c = 2'b11;
            default:              match_c      = 1'b0;
        endcase
    end

    // Lock state and classification registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            mc_q         <= '0;
            locked_q     <= 1'b0;
            mode_q       <= 2'b00;
            mode_valid_q <= 1'b0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mc_q         <= mc_d;
            locked_q     <= locked_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
        end
    end

    // Next state: acts one clk after each vsync edge; a saturated counter overrides.
    always_comb begin
        state_d      = state_q;
        mc_d         = mc_q;
        locked_d     = locked_q;
        mode_d       = mode_q;
        mode_valid_d = mode_valid_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        if (timeout_c) begin
            state_d      = SEARCH;
            mc_d         = '0;
            locked_d     = 1'b0;
            mode_valid_d = 1'b0;
        end else if (frame_strobe_q) begin
            mode_valid_d = match_c;
            if (match_c) begin
                mode_d = match_mode_c;
            end
            prev_d     = pair_c;
            prev_vld_d = 1'b1;
            case (state_q)
                SEARCH: begin
                    // First measurement after search spans a partial frame.
                    state_d    = MEASURE;
                    mc_d       = '0;
                    prev_vld_d = 1'b0;
                end
                MEASURE: begin
                    if (prev_vld_q && (pair_c == prev_q) && match_c) begin
                        mc_d = mc_q + MCW'(1);
                        if (mc_d == LOCK_MC) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        mc_d = '0;
                    end
                end
                LOCKED: begin
                    if (pair_c != prev_q) begin
                        state_d  = MEASURE;
                        mc_d     = '0;
                        locked_d = 1'b0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    mc_d    = '0;
                end
            endcase
        end
    end

    assign hcnt         = hcnt_q;
    assign vcnt         = vcnt_q;
    assign line_len     = line_len_q;
    assign frame_lines  = frame_lines_q;
    assign frame_strobe = frame_strobe_q;
    assign locked       = locked_q;
    assign mode         = mode_q;
    assign mode_valid   = mode_valid_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Scoreboard bench for video_timing_detector: randomized compressed frames,
// reference model at clken-sample / frame-event level.
module tb_video_timing_detector;

    localparam int LF = 2;

    logic       clk, rst, clken, hsync_in, vsync_in;
    logic [8:0] hcnt, vcnt, line_len, frame_lines;
    logic       frame_strobe, locked, mode_valid;
    logic [1:0] mode;

    video_timing_detector #(.LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst(rst), .clken(clken),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hcnt(hcnt), .vcnt(vcnt), .line_len(line_len), .frame_lines(frame_lines),
        .frame_strobe(frame_strobe), .locked(locked), .mode(mode), .mode_valid(mode_valid)
    );

    typedef struct { int cyc; int h; int v; } cyc_t;
    typedef struct { int cyc; int ll; int fl; int md; bit mv; bit lk; } ev_t;

    cyc_t cq[$];
    ev_t  eq[$];
    int   hist[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state
    bit m_hs, m_vs, m_mv, m_locked, m_search;
    int m_h, m_v, m_ll, m_fl, m_mode;

    int ce_div = 1;
    bit ce_rand = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic void classify(input int ll, input int fl, output bit v, output int md);
        v = 1'b1;
        md = 0;
        if (ll == 447 && fl == 311)      md = 0;
        else if (ll == 455 && fl == 310) md = 1;
        else if (ll == 447 && fl == 319) md = 2;
        else if (ll == 447 && fl == 261) md = 3;
        else v = 1'b0;
    endfunction

    task automatic model_reset();
        m_hs = 1; m_vs = 1; m_h = 0; m_v = 0; m_ll = 0; m_fl = 0;
        m_mode = 0; m_mv = 0; m_locked = 0; m_search = 1;
        hist.delete();
    endtask

    // Frame-level lock decision: lock after LF+1 identical valid measurements in a row.
    task automatic model_event(input bit to);
        int pair, md, run;
        bit v;
        pair = m_ll * 512 + m_fl;
        classify(m_ll, m_fl, v, md);
        if (to) begin
            m_search = 1; m_locked = 0; m_mv = 0; hist.delete();
        end else begin
            m_mv = v;
            if (v) m_mode = md;
            if (m_search) begin
                m_search = 0;
                hist.delete();
            end else if (m_locked) begin
                if (pair != hist[$]) begin
                    m_locked = 0;
                    hist.delete();
                    hist.push_back(pair);
                end
            end else begin
                hist.push_back(pair);
                run = 0;
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i] != pair) break;
                    run++;
                end
                if (v && run >= LF + 1) m_locked = 1;
            end
        end
    endtask

    task automatic model_sample(input bit hs, input bit vs);
        bit hedge, vedge, to;
        int old_v;
        hedge = m_hs && !hs;
        vedge = m_vs && !vs;
        m_hs = hs;
        m_vs = vs;
        old_v = m_v;
        if (hedge) begin
            m_ll = m_h;
            m_h = 0;
        end else if (m_h < 511) begin
            m_h++;
        end
        if (vedge) begin
            m_fl = (old_v - 1 + int'(hedge)) & 511;
            m_v = 0;
        end else if (hedge && m_v < 511) begin
            m_v++;
        end
        to = (m_h == 511) || (m_v == 511);
        if (vedge) begin
            model_event(to);
            eq.push_back('{cyc: cyc + 1, ll: m_ll, fl: m_fl, md: m_mode, mv: m_mv, lk: m_locked});
        end else if (to) begin
            m_search = 1; m_locked = 0; m_mv = 0; hist.delete();
        end
    endtask

    task automatic drive_cycle(input bit ce, input bit hs, input bit vs);
        clken = ce;
        hsync_in = hs;
        vsync_in = vs;
        if (ce) model_sample(hs, vs);
        cq.push_back('{cyc: cyc + 1, h: m_h, v: m_v});
        @(posedge clk);
        #2;
    endtask

    // One pixel sample, preceded by clken-off cycles carrying random glitches.
    task automatic pix(input bit hs, input bit vs);
        int gap;
        gap = ce_rand ? int'($urandom_range(0, 1)) : ce_div - 1;
        for (int g = 0; g < gap; g++) drive_cycle(1'b0, 1'($urandom), 1'($urandom));
        drive_cycle(1'b1, hs, vs);
    endtask

    // Compressed frame: short random lines, true-length final line before vsync.
    task automatic gen_frame(input int nlines, input int last_len, input bit coinc, input bit hs_on);
        int len, vst;
        bit hs, vs;
        vst = coinc ? 0 : 1;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == nlines - 1) ? last_len : int'($urandom_range(3, 6));
            for (int p = 0; p < len; p++) begin
                hs = !(hs_on && p < 2);
                vs = !(ln == 0 && p >= vst && p < vst + 3);
                pix(hs, vs);
            end
        end
    endtask

    task automatic dchk(input string nm, input int lk, input int md, input int mv);
        check({nm, "_locked"}, 32'(locked), lk);
        check({nm, "_mode"}, 32'(mode), md);
        check({nm, "_mode_valid"}, 32'(mode_valid), mv);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_hcnt"}, 32'(hcnt), 0);
        check({nm, "_vcnt"}, 32'(vcnt), 0);
        check({nm, "_line_len"}, 32'(line_len), 0);
        check({nm, "_frame_lines"}, 32'(frame_lines), 0);
        check({nm, "_frame_strobe"}, 32'(frame_strobe), 0);
        check({nm, "_locked"}, 32'(locked), 0);
        check({nm, "_mode"}, 32'(mode), 0);
        check({nm, "_mode_valid"}, 32'(mode_valid), 0);
    endtask

    // Monitor: per-cycle counter scoreboard plus per-vsync-event scoreboard.
    bit  pend = 0;
    ev_t pend_ev;
    always @(negedge clk) begin
        ev_t e;
        cyc_t c;
        if (rst) begin
            pend = 0;
        end else begin
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                c = cq.pop_front();
                check("hcnt", 32'(hcnt), c.h);
                check("vcnt", 32'(vcnt), c.v);
            end
            if (pend) begin
                pend = 0;
                check("ev_mode", 32'(mode), pend_ev.md);
                check("ev_mode_valid", 32'(mode_valid), 32'(pend_ev.mv));
                check("ev_locked", 32'(locked), 32'(pend_ev.lk));
            end
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                e = eq.pop_front();
                check("frame_strobe_hi", 32'(frame_strobe), 1);
                check("ev_line_len", 32'(line_len), e.ll);
                check("ev_frame_lines", 32'(frame_lines), e.fl);
                pend_ev = e;
                pend = 1;
            end else begin
                check("frame_strobe_lo", 32'(frame_strobe), 0);
            end
        end
    end

    initial begin
        rst = 1'b1; clken = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) drive_cycle(1'b1, 1'b1, 1'b1);

        // 48K, clken every cycle
        repeat (5) gen_frame(312, 448, 1'b0, 1'b1);
        dchk("k48", 1, 0, 1);

        // Pentagon while locked
        repeat (4) gen_frame(320, 448, 1'b0, 1'b1);
        dchk("pent", 1, 2, 1);

        // coincident h/v edges, 312 lines
        repeat (2) gen_frame(312, 448, 1'b1, 1'b1);
        check("coinc_frame_lines", 32'(frame_lines), 311);
        dchk("coinc", 0, 0, 1);

        // NTSC with coincident edges
        repeat (4) gen_frame(262, 448, 1'b1, 1'b1);
        dchk("ntsc", 1, 3, 1);

        // unknown 400x300 with random clken gaps
        ce_rand = 1;
        repeat (3) gen_frame(300, 400, 1'b0, 1'b1);
        ce_rand = 0;
        check("unk_frame_lines", 32'(frame_lines), 299);
        dchk("unknown", 0, 3, 0);

        // 128K, clken every other cycle
        ce_div = 2;
        repeat (4) gen_frame(311, 456, 1'b0, 1'b1);
        ce_div = 1;
        dchk("k128", 1, 1, 1);

        // hsync removed while locked
        gen_frame(312, 448, 1'b0, 1'b0);
        check("nohs_hcnt", 32'(hcnt), 511);
        dchk("nohs", 0, 1, 0);

        // stream restored
        repeat (4) gen_frame(312, 448, 1'b0, 1'b1);
        dchk("restore", 1, 0, 1);

        // mid-frame asynchronous reset
        for (int p = 0; p < 40; p++) pix(1'((p % 5) >= 2), 1'b1);
        #1;
        rst = 1'b1;
        clken = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        #1;
        check_all_zero("midreset");
        cq.delete();
        eq.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) drive_cycle(1'b1, 1'b1, 1'b1);
        repeat (2) gen_frame(312, 448, 1'b0, 1'b1);
        repeat (4) drive_cycle(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("events_drained", 32'(eq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
